// File: rtl/zipdbg_pkg.sv
// Shared types and constants for the ZipCPU debug-bus bridge.
// State encoding, control-word bit positions and host address map.
package zipdbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_POLL,
    S_DATA,
    S_RESP
  } state_e;

  localparam int CTL_HALT   = 10;
  localparam int CTL_NSTALL = 9;
  localparam int CTL_STEP   = 8;
  localparam int CTL_RESET  = 6;
  localparam logic [4:0] CTL_ADDR_MASK = 5'h1f;

  localparam logic [5:0] WB_CTRL_ADDR = 6'h00;
  localparam int         WB_REG_BIT   = 5;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
  } req_t;

  // Halt set; step, reset and clear-cache left clear.
  function automatic logic [31:0] ctrl_word(
    input logic [4:0] r
  );
    logic [31:0] w;
    w           = '0;
    w[CTL_HALT] = 1'b1;
    w[4:0]      = r & CTL_ADDR_MASK;
    return w;
  endfunction

endpackage

// File: rtl/zipdbg_timeout.sv
// Wait-cycle counter for the debug bridge.
// Expires after 2^LGTIMEOUT cycles without a clear.
module zipdbg_timeout #(
  parameter int LGTIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_expired
);

  logic [LGTIMEOUT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clr) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_expired = &cnt_q;

endmodule

// File: rtl/zipdbg_bridge.sv
// Host Wishbone to ZipCPU two-word debug port bridge.
// Optional address cache: define ZIPDBG_ADDR_CACHE_EN.
module zipdbg_bridge
  import zipdbg_pkg::*;
#(
  parameter int LGTIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [5:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  output logic        o_dbg_cyc,
  output logic        o_dbg_stb,
  output logic        o_dbg_we,
  output logic        o_dbg_addr,
  output logic [31:0] o_dbg_data,
  input  logic        i_dbg_ack,
  input  logic        i_dbg_stall,
  input  logic [31:0] i_dbg_data
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        stall_q, stall_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic        adr_q, adr_d;
  logic [31:0] dout_q, dout_d;
  logic        tmo_clr, tmo_exp;
  logic        in_wait, hit;
  logic        cache_set, cache_inv;

  zipdbg_timeout #(
    .LGTIMEOUT(LGTIMEOUT)
  ) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (tmo_clr),
    .o_expired(tmo_exp)
  );

`ifdef ZIPDBG_ADDR_CACHE_EN
  logic       cv_q, cv_d;
  logic [4:0] ca_q, ca_d;

  always_comb begin
    cv_d = cv_q;
    ca_d = ca_q;
    if (cache_set) begin
      cv_d = 1'b1;
      ca_d = req_q.addr[4:0];
    end
    if (cache_inv) cv_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cv_q <= 1'b0;
      ca_q <= '0;
    end else begin
      cv_q <= cv_d;
      ca_q <= ca_d;
    end
  end

  assign hit = cv_q && (ca_q == i_wb_addr[4:0]);
`else
  logic unused_cache;
  assign unused_cache = cache_set ^ cache_inv;
  assign hit = 1'b0;
`endif

  assign in_wait = (state_q == S_CTRL) ||
                   (state_q == S_POLL) ||
                   (state_q == S_DATA);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dout_d    = dout_q;
    tmo_clr   = !in_wait;
    cache_set = 1'b0;
    cache_inv = 1'b0;

    if (stb_q && !i_dbg_stall) stb_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (i_wb_cyc && i_wb_stb) begin
          req_d = '{we: i_wb_we, addr: i_wb_addr,
                    data: i_wb_data};
          unique case (1'b1)
            (i_wb_addr == WB_CTRL_ADDR): begin
              state_d   = S_DATA;
              cyc_d     = 1'b1;
              stb_d     = 1'b1;
              we_d      = i_wb_we;
              adr_d     = 1'b0;
              dout_d    = i_wb_data;
              cache_inv = i_wb_we;
            end
            i_wb_addr[WB_REG_BIT]: begin
              cyc_d = 1'b1;
              stb_d = 1'b1;
              if (hit) begin
                state_d = S_DATA;
                we_d    = i_wb_we;
                adr_d   = 1'b1;
                dout_d  = i_wb_data;
              end else begin
                state_d = S_CTRL;
                we_d    = 1'b1;
                adr_d   = 1'b0;
                dout_d  = ctrl_word(i_wb_addr[4:0]);
              end
            end
            default: begin
              state_d = S_RESP;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_CTRL: begin
        if (i_dbg_ack) begin
          state_d = S_POLL;
          tmo_clr = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = 1'b0;
        end
      end
      S_POLL: begin
        if (i_dbg_ack) begin
          tmo_clr = 1'b1;
          stb_d   = 1'b1;
          if (i_dbg_data[CTL_NSTALL]) begin
            state_d   = S_DATA;
            we_d      = req_q.we;
            adr_d     = 1'b1;
            dout_d    = req_q.data;
            cache_set = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_dbg_ack) begin
          state_d = S_RESP;
          tmo_clr = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          rdata_d = i_dbg_data;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    // Route timeout errors through RESP so stall covers the err cycle.
    if (in_wait && !i_dbg_ack && tmo_exp) begin
      state_d   = S_RESP;
      err_d     = 1'b1;
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      cache_set = 1'b0;
      cache_inv = 1'b1;
    end

    if ((state_q != S_IDLE) && !i_wb_cyc) begin
      state_d   = S_IDLE;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      cache_set = 1'b0;
      cache_inv = 1'b1;
    end
  end

  assign stall_d = (state_d != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_stall = stall_q;
  assign o_wb_data  = rdata_q;
  assign o_dbg_cyc  = cyc_q;
  assign o_dbg_stb  = stb_q;
  assign o_dbg_we   = we_q;
  assign o_dbg_addr = adr_q;
  assign o_dbg_data = dout_q;

endmodule

// File: tb/tb_zipdbg_bridge.sv
// Directed bench for zipdbg_bridge with a behavioural debug slave.
// Honours ZIPDBG_ADDR_CACHE_EN for the cache-hit expectations.
module tb_zipdbg_bridge;

`ifdef ZIPDBG_ADDR_CACHE_EN
  localparam int HIT_N = 3;
`else
  localparam int HIT_N = 7;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [5:0]  wb_addr = '0;
  logic [31:0] wb_wdat = '0;
  logic        o_wb_ack, o_wb_stall, o_wb_err;
  logic [31:0] o_wb_data;
  logic        o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        dbg_ack = 1'b0;
  logic        dbg_stall = 1'b0;
  logic [31:0] dbg_rdat = '0;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  zipdbg_bridge #(.LGTIMEOUT(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wb_cyc   (wb_cyc),
    .i_wb_stb   (wb_stb),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_wdat),
    .o_wb_ack   (o_wb_ack),
    .o_wb_stall (o_wb_stall),
    .o_wb_err   (o_wb_err),
    .o_wb_data  (o_wb_data),
    .o_dbg_cyc  (o_dbg_cyc),
    .o_dbg_stb  (o_dbg_stb),
    .o_dbg_we   (o_dbg_we),
    .o_dbg_addr (o_dbg_addr),
    .o_dbg_data (o_dbg_data),
    .i_dbg_ack  (dbg_ack),
    .i_dbg_stall(dbg_stall),
    .i_dbg_data (dbg_rdat)
  );

  // Slave: zero stall, one-cycle ack, logs {we, addr, data}.
  logic        ack_en = 1'b1;
  int          ready_at = 0;
  int          nrd = 0;
  int          ntx = 0;
  logic [31:0] reg_val = 32'h1234_5678;
  logic [33:0] txlog [64];

  always @(posedge i_clk) begin
    dbg_ack <= 1'b0;
    if (o_dbg_cyc && o_dbg_stb && !dbg_stall && ack_en) begin
      dbg_ack <= 1'b1;
      txlog[ntx & 63] <= {o_dbg_we, o_dbg_addr, o_dbg_data};
      ntx <= ntx + 1;
      if (!o_dbg_addr && !o_dbg_we) begin
        dbg_rdat <= (nrd >= ready_at) ? 32'h600 : 32'h400;
        nrd <= nrd + 1;
      end else if (o_dbg_addr && !o_dbg_we) begin
        dbg_rdat <= reg_val;
      end else begin
        dbg_rdat <= '0;
        if (o_dbg_addr) reg_val <= o_dbg_data;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [5:0] a,
                      input logic [31:0] d, input int stop_at,
                      input bit do_rst, output int n,
                      output logic [31:0] rd,
                      output logic got_ack, output logic got_err);
    bit done;
    @(posedge i_clk);
    @(negedge i_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1;
    wb_we = we; wb_addr = a; wb_wdat = d;
    @(posedge i_clk);
    #1 wb_stb = 1'b0;
    n = 1; done = 0;
    got_ack = 1'b0; got_err = 1'b0; rd = '0;
    while (!done && n <= 40) begin
      if (o_wb_ack || o_wb_err) begin
        got_ack = o_wb_ack; got_err = o_wb_err;
        rd = o_wb_data; done = 1;
        wb_cyc = 1'b0;
      end else if (n == stop_at) begin
        if (do_rst) i_rst_n = 1'b0;
        else        wb_cyc = 1'b0;
        done = 1;
      end else begin
        @(posedge i_clk);
        #1 n++;
      end
    end
    if (!done) begin
      wb_cyc = 1'b0;
      chk("xfer_bound", 96'(n), 96'(40));
    end
  endtask

  function automatic logic [95:0] all_out();
    return 96'({o_wb_ack, o_wb_stall, o_wb_err, o_wb_data,
                o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr,
                o_dbg_data});
  endfunction

  int          n, base, cnt;
  logic [31:0] rd;
  logic        ga, ge;

  initial begin
    repeat (3) @(posedge i_clk);
    #1 chk("reset_outs", all_out(), 96'(0));
    @(negedge i_clk) i_rst_n = 1'b1;
    #1 chk("idle_stall", 96'(o_wb_stall), 96'(0));

    base = ntx;
    xfer(0, 6'h25, 0, 0, 0, n, rd, ga, ge);
    chk("rd25_cyc", 96'(n), 96'(7));
    chk("rd25_ack", 96'({ga, ge}), 96'(2'b10));
    chk("rd25_data", 96'(rd), 96'(32'h1234_5678));
    chk("rd25_ntx", 96'(ntx - base), 96'(3));
    chk("rd25_tx0", 96'(txlog[base & 63]),
        96'({2'b10, 32'h405}));
    chk("rd25_tx1", 96'(txlog[(base + 1) & 63] >> 32),
        96'(2'b00));
    chk("rd25_tx2", 96'(txlog[(base + 2) & 63] >> 32),
        96'(2'b01));

    base = ntx;
    ready_at = nrd + 2;
    xfer(0, 6'h25, 0, 0, 0, n, rd, ga, ge);
    chk("poll3_cyc", 96'(n), 96'(11));
    chk("poll3_ntx", 96'(ntx - base), 96'(5));

    base = ntx;
    xfer(1, 6'h00, 32'h0, 0, 0, n, rd, ga, ge);
    chk("pt_wr_cyc", 96'(n), 96'(3));
    chk("pt_wr_tx", 96'(txlog[base & 63]), 96'({2'b10, 32'h0}));

    base = ntx;
    xfer(1, 6'h25, 32'hA5A5, 0, 0, n, rd, ga, ge);
    chk("wr25_cyc", 96'(n), 96'(7));
    chk("wr25_tx2", 96'(txlog[(base + 2) & 63]),
        96'({2'b11, 32'hA5A5}));
    xfer(0, 6'h25, 0, 0, 0, n, rd, ga, ge);
    chk("rd25_hit_cyc", 96'(n), 96'(HIT_N));
    chk("rd25_hit_data", 96'(rd), 96'(32'hA5A5));

    xfer(1, 6'h00, 32'h0, 0, 0, n, rd, ga, ge);
    base = ntx;
    xfer(0, 6'h25, 0, 0, 0, n, rd, ga, ge);
    chk("rd25_inv_cyc", 96'(n), 96'(7));
    chk("rd25_inv_tx0", 96'(txlog[base & 63]),
        96'({2'b10, 32'h405}));

    ack_en = 1'b0;
    xfer(0, 6'h26, 0, 0, 0, n, rd, ga, ge);
    chk("tmo_cyc", 96'(n), 96'(17));
    chk("tmo_flags", 96'({ga, ge}), 96'(2'b01));
    chk("tmo_dbgcyc", 96'(o_dbg_cyc), 96'(0));
    ack_en = 1'b1;

    ready_at = nrd + 100;
    xfer(0, 6'h27, 0, 4, 0, n, rd, ga, ge);
    chk("abort_at", 96'(n), 96'(4));
    @(posedge i_clk);
    #1 chk("abort_dbg", 96'({o_dbg_cyc, o_dbg_stb}), 96'(0));
    cnt = 0;
    repeat (5) begin
      @(posedge i_clk);
      #1 if (o_wb_ack || o_wb_err) cnt++;
    end
    chk("abort_noresp", 96'(cnt), 96'(0));
    ready_at = nrd;
    xfer(0, 6'h28, 0, 0, 0, n, rd, ga, ge);
    chk("post_abort_cyc", 96'(n), 96'(7));

    xfer(0, 6'h29, 0, 5, 1, n, rd, ga, ge);
    chk("rst_at", 96'(n), 96'(5));
    #1 chk("rst_outs", all_out(), 96'(0));
    wb_cyc = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;

    base = ntx;
    xfer(0, 6'h30, 0, 0, 0, n, rd, ga, ge);
    chk("rd30_cyc", 96'(n), 96'(7));
    chk("rd30_tx0", 96'(txlog[base & 63]),
        96'({2'b10, 32'h410}));

    base = ntx;
    xfer(0, 6'h10, 0, 0, 0, n, rd, ga, ge);
    chk("rsv_cyc", 96'(n), 96'(1));
    chk("rsv_flags", 96'({ga, ge}), 96'(2'b01));
    chk("rsv_stall", 96'(o_wb_stall), 96'(1));
    repeat (3) @(posedge i_clk);
    chk("rsv_ntx", 96'(ntx - base), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
